// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: state encoding and endpoint-number width shared by the USB FS schedulers.
package usb_fs_pkg;
    localparam int EP_W = 4;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;
    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        CAPTURE = ST_CAPTURE,
        PRESENT = ST_PRESENT
    } arb_state_e;
endpackage

// File: rtl/usb_fs_rr_pick.sv
// usb_fs_rr_pick: picks the first set request at or after ptr, searching circularly modulo N.
module usb_fs_rr_pick
    import usb_fs_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]      req,
    input  logic [EP_W-1:0]   ptr,
    output logic [EP_W-1:0]   gnt_idx,
    output logic              gnt_any
);
    logic [N-1:0] rot;
    logic [EP_W:0] sum;

    // Rotate so bit 0 is the ptr position; lowest offset wins by being assigned last.
    always_comb begin
        rot = N'({req, req} >> ptr);
        gnt_any = |req;
        gnt_idx = '0;
        sum = '0;
        for (int j = N - 1; j >= 0; j--) begin
            sum = (EP_W + 1)'(ptr) + (EP_W + 1)'(j);
            if (rot[j]) gnt_idx = sum >= (EP_W + 1)'(N) ? EP_W'(sum - (EP_W + 1)'(N)) : EP_W'(sum);
        end
    end
endmodule

// File: rtl/usb_fs_out_drain_arb.sv
// usb_fs_out_drain_arb: round-robin drain of OUT endpoint buffers into one tagged byte stream.
// Define USB_OUT_ARB_EP0_PRIO_EN to give EP0 absolute priority without advancing rr_ptr.
module usb_fs_out_drain_arb #(
    parameter int NUM_OUT_EPS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
    input  logic [NUM_OUT_EPS-1:0] out_ep_setup,
    input  logic [7:0]             out_ep_data,
    output logic [NUM_OUT_EPS-1:0] out_ep_data_get,
    input  logic [NUM_OUT_EPS-1:0] ep_enable,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [7:0]             pkt_data,
    output logic [3:0]             pkt_ep,
    output logic                   pkt_setup,
    output logic                   pkt_first,
    output logic                   pkt_last,
    output logic                   busy
);
    import usb_fs_pkg::*;

    arb_state_e state_q, state_d;
    logic [EP_W-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick_ptr, gnt_idx, ptr_next, ptr_inc;
    logic first_q, first_d, valid_q, valid_d, setup_q, setup_d, pfirst_q, pfirst_d, plast_q, plast_d;
    logic [7:0] data_q, data_d;
    logic [NUM_OUT_EPS-1:0] cand, grant_oh, pick_oh;
    logic gnt_any, grant_avail;

    assign cand = out_ep_data_avail & ep_enable;
    assign grant_oh = NUM_OUT_EPS'(1) << grant_q;
    assign pick_oh = NUM_OUT_EPS'(1) << gnt_idx;
    assign grant_avail = |(out_ep_data_avail & grant_oh);
    assign ptr_inc = grant_q == EP_W'(NUM_OUT_EPS - 1) ? '0 : grant_q + EP_W'(1);
`ifdef USB_OUT_ARB_EP0_PRIO_EN
    assign pick_ptr = cand[0] ? '0 : rr_ptr_q;
    assign ptr_next = grant_q == '0 ? rr_ptr_q : ptr_inc;
`else
    assign pick_ptr = rr_ptr_q;
    assign ptr_next = ptr_inc;
`endif

    usb_fs_rr_pick #(.N(NUM_OUT_EPS)) u_pick (
        .req     (cand),
        .ptr     (pick_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d = grant_q;
        first_d = first_q;
        valid_d = valid_q;
        setup_d = setup_q;
        pfirst_d = pfirst_q;
        plast_d = plast_q;
        data_d = data_q;
        case (state_q)
            IDLE: if (gnt_any) begin
                grant_d = gnt_idx;
                setup_d = |(out_ep_setup & pick_oh);
                first_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = grant_avail ? CAPTURE : IDLE;
                rr_ptr_d = grant_avail ? rr_ptr_q : ptr_next;
            end
            // PE avail already reflects the post-get address, so it marks the final byte.
            CAPTURE: begin
                data_d = out_ep_data;
                pfirst_d = first_q;
                plast_d = !grant_avail;
                first_d = 1'b0;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: if (pkt_ready) begin
                valid_d = 1'b0;
                state_d = plast_q ? IDLE : ISSUE;
                rr_ptr_d = plast_q ? ptr_next : rr_ptr_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            grant_q <= '0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
            setup_q <= 1'b0;
            pfirst_q <= 1'b0;
            plast_q <= 1'b0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q <= grant_d;
            first_q <= first_d;
            valid_q <= valid_d;
            setup_q <= setup_d;
            pfirst_q <= pfirst_d;
            plast_q <= plast_d;
            data_q <= data_d;
        end
    end

    assign out_ep_data_get = (state_q == ISSUE && grant_avail) ? grant_oh : '0;
    assign busy = state_q != IDLE;
    assign pkt_valid = valid_q;
    assign pkt_data = data_q;
    assign pkt_ep = grant_q;
    assign pkt_setup = setup_q;
    assign pkt_first = pfirst_q;
    assign pkt_last = plast_q;
endmodule

// File: tb/tb_usb_fs_out_drain_arb.sv
// tb_usb_fs_out_drain_arb: directed bench with a small OUT PE buffer model and handshake log.
module tb_usb_fs_out_drain_arb;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] avail, setup, get, enable, kill;
    logic [7:0] pe_data = 8'h00;
    logic pkt_valid, pkt_ready, pkt_setup, pkt_first, pkt_last, busy;
    logic [7:0] pkt_data;
    logic [3:0] pkt_ep;

    logic [7:0] mem [4][64];
    int len [4] = '{default: 0};
    int rd [4] = '{default: 0};
    int gets [4] = '{default: 0};
    logic multi = 1'b0;
    logic [14:0] log_q [$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usb_fs_out_drain_arb #(.NUM_OUT_EPS(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .out_ep_data_avail (avail),
        .out_ep_setup      (setup),
        .out_ep_data       (pe_data),
        .out_ep_data_get   (get),
        .ep_enable         (enable),
        .pkt_valid         (pkt_valid),
        .pkt_ready         (pkt_ready),
        .pkt_data          (pkt_data),
        .pkt_ep            (pkt_ep),
        .pkt_setup         (pkt_setup),
        .pkt_first         (pkt_first),
        .pkt_last          (pkt_last),
        .busy              (busy)
    );

    always_comb begin
        avail = '0;
        for (int e = 0; e < 4; e++) avail[e] = (rd[e] < len[e]) && !kill[e];
    end

    always @(posedge clk) begin
        if ($countones(get) > 1) multi <= 1'b1;
        for (int e = 0; e < 4; e++) begin
            if (get[e]) begin
                pe_data <= mem[e][rd[e]];
                rd[e] <= rd[e] + 1;
                gets[e] <= gets[e] + 1;
            end
        end
        if (reset_n && pkt_valid && pkt_ready) log_q.push_back({pkt_ep, pkt_setup, pkt_first, pkt_last, pkt_data});
    end

    function automatic logic [14:0] mk(int ep, bit s, bit f, bit l, logic [7:0] d);
        return {4'(ep), s, f, l, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int e, input int n, input logic [7:0] base, input logic [7:0] step);
        for (int k = 0; k < n; k++) mem[e][len[e] + k] = base + 8'(k) * step;
        len[e] = len[e] + n;
    endtask

    task automatic wait_log(input int n);
        int c = 0;
        while (log_q.size() < n && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("log_timeout", 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_valid();
        int c = 0;
        while (!pkt_valid && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("valid_timeout", 32'(pkt_valid), 32'd1);
    endtask

`ifdef USB_OUT_ARB_EP0_PRIO_EN
    localparam int ORD [4] = '{0, 2, 3, 1};
    localparam int EP0_POS = 0, EP2_POS = 8, RR_AFTER = 3;
`else
    localparam int ORD [4] = '{2, 3, 0, 1};
    localparam int EP0_POS = 1, EP2_POS = 0, RR_AFTER = 1;
`endif

    initial begin
        int g;
        pkt_ready = 1'b1;
        enable = 4'hF;
        setup = 4'h0;
        kill = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(pkt_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_get", 32'(get), 0);
        chk("rst_pkt", 32'({pkt_data, pkt_ep, pkt_setup, pkt_first, pkt_last}), 0);
        chk("rst_ptr", 32'(dut.rr_ptr_q), 0);
        reset_n = 1'b1;

        load(1, 3, 8'h11, 8'h11);
        @(negedge clk);
        chk("t1_get_a", 32'(get), 32'h2);
        chk("t1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t1_get_off", 32'(get), 0);
        chk("t1_novalid", 32'(pkt_valid), 0);
        @(negedge clk);
        chk("t1_lat3", 32'(pkt_valid), 1);
        chk("t1_b0", 32'({pkt_ep, pkt_setup, pkt_first, pkt_last, pkt_data}), 32'(mk(1, 0, 1, 0, 8'h11)));
        @(negedge clk);
        chk("t1_get_b", 32'(get), 32'h2);
        wait_log(3);
        chk("t1_e0", 32'(log_q[0]), 32'(mk(1, 0, 1, 0, 8'h11)));
        chk("t1_e1", 32'(log_q[1]), 32'(mk(1, 0, 0, 0, 8'h22)));
        chk("t1_e2", 32'(log_q[2]), 32'(mk(1, 0, 0, 1, 8'h33)));
        chk("t1_gets", 32'(gets[1]), 3);
        chk("t1_ptr", 32'(dut.rr_ptr_q), 2);

        log_q.delete();
        for (int e = 0; e < 4; e++) load(e, 2, 8'(e * 16 + 1), 8'h01);
        wait_log(8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("t2_e%0d", k), 32'(log_q[k]),
                32'(mk(ORD[k / 2], 0, k % 2 == 0, k % 2 == 1, 8'(ORD[k / 2] * 16 + 1 + k % 2))));
        repeat (2) @(negedge clk);
        chk("t2_idle", 32'(busy), 0);
        chk("t2_ptr", 32'(dut.rr_ptr_q), 2);

        log_q.delete();
        pkt_ready = 1'b0;
        g = gets[2];
        load(2, 3, 8'h5A, 8'h11);
        wait_valid();
        chk("t3_b0", 32'(pkt_data), 32'h5A);
        pkt_ready = 1'b1;
        @(negedge clk);
        pkt_ready = 1'b0;
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold", 32'({pkt_valid, pkt_data}), 32'h16B);
        end
        chk("t3_noget", 32'(gets[2] - g), 2);
        pkt_ready = 1'b1;
        wait_log(3);
        chk("t3_e0", 32'(log_q[0]), 32'(mk(2, 0, 1, 0, 8'h5A)));
        chk("t3_e1", 32'(log_q[1]), 32'(mk(2, 0, 0, 0, 8'h6B)));
        chk("t3_e2", 32'(log_q[2]), 32'(mk(2, 0, 0, 1, 8'h7C)));
        chk("t3_gets", 32'(gets[2] - g), 3);

        log_q.delete();
        load(1, 1, 8'hC1, 8'h00);
        wait_log(1);
        chk("t4_pre", 32'(dut.rr_ptr_q), 2);
        log_q.delete();
        setup = 4'h1;
        load(0, 8, 8'h80, 8'h01);
        load(2, 1, 8'h99, 8'h00);
        wait_log(9);
        chk("t4_ep2", 32'(log_q[EP2_POS]), 32'(mk(2, 0, 1, 1, 8'h99)));
        for (int k = 0; k < 8; k++)
            chk($sformatf("t4_setup%0d", k), 32'(log_q[EP0_POS + k]), 32'(mk(0, 1, k == 0, k == 7, 8'(8'h80 + k))));
        @(negedge clk);
        chk("t4_ptr", 32'(dut.rr_ptr_q), RR_AFTER);
        setup = 4'h0;

        log_q.delete();
        g = gets[3];
        load(3, 2, 8'hD0, 8'h01);
        @(negedge clk);
        kill[3] = 1'b1;
        #1;
        chk("t5_noget", 32'(get), 0);
        @(negedge clk);
        chk("t5_idle", 32'({busy, pkt_valid}), 0);
        chk("t5_ptr", 32'(dut.rr_ptr_q), 0);
        chk("t5_gets", 32'(gets[3] - g), 0);
        len[3] = rd[3];
        kill[3] = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_nolog", 32'(log_q.size()), 0);

        pkt_ready = 1'b0;
        load(1, 2, 8'hB0, 8'h01);
        wait_valid();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(pkt_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ptr", 32'(dut.rr_ptr_q), 0);
        len[1] = rd[1];
        pkt_ready = 1'b1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_nolog", 32'(log_q.size()), 0);

        g = gets[1];
        enable = 4'b1101;
        load(1, 1, 8'hE1, 8'h00);
        load(2, 1, 8'hE2, 8'h00);
        wait_log(1);
        chk("t6_ep2", 32'(log_q[0]), 32'(mk(2, 0, 1, 1, 8'hE2)));
        repeat (10) @(negedge clk);
        chk("t6_skip", 32'(log_q.size()), 1);
        chk("t6_noget1", 32'(gets[1] - g), 0);
        chk("t6_busy", 32'(busy), 0);
        enable = 4'hF;
        wait_log(2);
        chk("t6_ep1", 32'(log_q[1]), 32'(mk(1, 0, 1, 1, 8'hE1)));
        @(negedge clk);
        chk("t6_ptr", 32'(dut.rr_ptr_q), 2);
        chk("get_onehot", 32'(multi), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
